alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: op-codes, default width and FSM states.
package alu_pkg;
  localparam int ALU_DW = 18;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_INC = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;
  localparam logic [3:0] ALU_DEC = 4'b0110;
  localparam logic [3:0] ALU_SHL = 4'b0111;
  localparam logic [3:0] ALU_SHR = 4'b1000;
  localparam logic [3:0] ALU_ADD = 4'b1001;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_MUL = 4'b1011;
  localparam logic [3:0] ALU_DIV = 4'b1100;
  localparam logic [3:0] ALU_CAT = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Ops outside NOP..CAT, and b/a with a==0, never reach the ALU.
  function automatic logic op_illegal(input logic [3:0] op, input logic a_zero);
    return (op == ALU_NOP) || (op > ALU_CAT) || ((op == ALU_DIV) && a_zero);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant pointer moves only on upd_i.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] win_o
);
  // last_q = 1 means requester 1 was granted last, so requester 0 is favoured.
  logic last_q, last_d;

  always_comb begin
    win_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = last_q ? 2'b01 : 2'b10;
      default: win_o = 2'b00;
    endcase
    if (upd_i && (win_o != 2'b00)) last_d = win_o[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one registered ALU; each transaction walks
// IDLE -> ISSUE -> CAPTURE -> RESP with operands latched at acceptance.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [3:0]    op0,
  input  logic [3:0]    op1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] res,
  output logic          res_lsb,
  output logic          res_neg,
  output logic          err,
  output logic [3:0]    alu_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_c,
  input  logic          alu_lsb,
  input  logic          alu_neg
);
  state_t        state_q, state_d;
  logic [1:0]    own_q, own_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          ill_q, ill_d;
  logic [DW-1:0] res_q, res_d;
  logic          lsb_q, lsb_d, neg_q, neg_d, err_q, err_d;

  logic          accept;
  logic [1:0]    win;

  assign accept = (state_q == ST_IDLE) && (req != 2'b00);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .upd_i (accept),
    .win_o (win)
  );

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    ill_d   = ill_q;
    res_d   = res_q;
    lsb_d   = lsb_q;
    neg_d   = neg_q;
    err_d   = err_q;
    gnt     = 2'b00;
    done    = 2'b00;
    alu_sel = ALU_NOP;
    alu_a   = '0;
    alu_b   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          own_d   = win;
          op_d    = win[1] ? op1 : op0;
          a_d     = win[1] ? a1  : a0;
          b_d     = win[1] ? b1  : b0;
          ill_d   = op_illegal(win[1] ? op1 : op0, (win[1] ? a1 : a0) == '0);
        end
      end
      ST_ISSUE: begin
        gnt     = own_q;
        alu_sel = ill_q ? ALU_NOP : op_q;
        alu_a   = a_q;
        alu_b   = b_q;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        res_d   = ill_q ? '0   : alu_c;
        lsb_d   = ill_q ? 1'b0 : alu_lsb;
        neg_d   = ill_q ? 1'b0 : alu_neg;
        err_d   = ill_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        done    = own_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      own_q   <= 2'b00;
      op_q    <= ALU_NOP;
      a_q     <= '0;
      b_q     <= '0;
      ill_q   <= 1'b0;
      res_q   <= '0;
      lsb_q   <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ill_q   <= ill_d;
      res_q   <= res_d;
      lsb_q   <= lsb_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign res     = res_q;
  assign res_lsb = lsb_q;
  assign res_neg = neg_q;
  assign err     = err_q;
endmodule
